// File: rtl/uart_rx_loader.sv
// UART receiver with start/parity/stop checking, feeding a little-endian word packer
// that emits auto-addressed write strobes and signals end-of-load after an idle timeout.
module uart_rx_loader #(
  parameter int unsigned CLK_FREQ     = 50000000,
  parameter int unsigned BAUD         = 9600,
  parameter int unsigned PARITY       = 0,
  parameter int unsigned WORD_BYTES   = 4,
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    uart_rx,
  input  logic                    en,
  output logic                    byte_valid,
  output logic [7:0]              byte_data,
  output logic                    frame_err,
  output logic                    parity_err,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [8*WORD_BYTES-1:0] wr_data,
  output logic                    load_done,
  output logic                    busy
);

  localparam int unsigned BIT_CNT   = CLK_FREQ / BAUD;
  localparam int unsigned HALF_CNT  = BIT_CNT / 2;
  localparam int unsigned CNT_W     = $clog2(BIT_CNT + 1);
  localparam int unsigned TMO_LIMIT = TIMEOUT_BITS * BIT_CNT;
  localparam int unsigned TMO_W     = $clog2(TMO_LIMIT + 1);
  localparam int unsigned IDX_W     = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int unsigned WORD_W    = 8 * WORD_BYTES;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [2:0]       state, state_nxt;
  logic             rx_s1, rx_s2, rx_prev;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             par_acc;
  logic             wait_high;
  logic [IDX_W-1:0] byte_idx;
  logic             pending, pending_nxt;
  logic             done_pend;
  logic [TMO_W-1:0] tmo_cnt;
  logic             fall, sample, stop_smp, par_bad, accept, tmo_run, expire, last_byte;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Receiver sequencing plus timeout/pending decisions
  always_comb begin
    state_nxt   = state;
    fall        = rx_prev & ~rx_s2;
    sample      = (state != S_IDLE) && (cnt == '0);
    stop_smp    = (state == S_STOP) && sample;
    par_bad     = 1'b0;
    if (PARITY == 1)      par_bad = par_acc;
    else if (PARITY == 2) par_bad = ~par_acc;
    accept      = stop_smp && rx_s2 && !par_bad;
    tmo_run     = en && (state == S_IDLE) && pending && !done_pend;
    expire      = tmo_run && (tmo_cnt == TMO_W'(TMO_LIMIT - 1));
    last_byte   = (byte_idx == IDX_W'(WORD_BYTES - 1));
    pending_nxt = pending;
    if (!en)                              pending_nxt = 1'b0;
    else if (accept)                      pending_nxt = 1'b1;
    else if (done_pend)                   pending_nxt = 1'b0;
    else if (expire && byte_idx == '0)    pending_nxt = 1'b0;
    case (state)
      S_IDLE:  if (fall && !wait_high) state_nxt = S_START;
      S_START: if (sample) state_nxt = rx_s2 ? S_IDLE : S_DATA;
      S_DATA:  if (sample && bit_idx == 3'd7) state_nxt = (PARITY != 0) ? S_PAR : S_STOP;
      S_PAR:   if (sample) state_nxt = S_STOP;
      S_STOP:  if (sample) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Synchroniser, bit timing, shift register and byte-level outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1      <= 1'b1;
      rx_s2      <= 1'b1;
      rx_prev    <= 1'b1;
      cnt        <= CNT_W'(HALF_CNT - 1);
      bit_idx    <= '0;
      shreg      <= '0;
      par_acc    <= 1'b0;
      wait_high  <= 1'b0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      if (state == S_IDLE)   cnt <= CNT_W'(HALF_CNT - 1);
      else if (cnt == '0)    cnt <= CNT_W'(BIT_CNT - 1);
      else                   cnt <= cnt - CNT_W'(1);
      if (state == S_IDLE) begin
        bit_idx <= '0;
        par_acc <= 1'b0;
      end else if (sample && state == S_DATA) begin
        shreg   <= {rx_s2, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
        par_acc <= par_acc ^ rx_s2;
      end else if (sample && state == S_PAR) begin
        par_acc <= par_acc ^ rx_s2;
      end
      // A bad stop bit leaves the line low; do not re-arm until it returns high
      if (stop_smp && !rx_s2) wait_high <= 1'b1;
      else if (rx_s2)         wait_high <= 1'b0;
      byte_valid <= accept;
      if (accept) byte_data <= shreg;
      frame_err  <= stop_smp && !rx_s2;
      parity_err <= stop_smp && par_bad;
      busy       <= (state_nxt != S_IDLE) || (en && pending_nxt);
    end
  end

  // Word packer, address generation and end-of-load timeout
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en     <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      load_done <= 1'b0;
      byte_idx  <= '0;
      pending   <= 1'b0;
      done_pend <= 1'b0;
      tmo_cnt   <= '0;
    end else begin
      wr_en     <= 1'b0;
      load_done <= 1'b0;
      pending   <= pending_nxt;
      if (!en) begin
        wr_addr   <= '0;
        wr_data   <= '0;
        byte_idx  <= '0;
        done_pend <= 1'b0;
        tmo_cnt   <= '0;
      end else begin
        if (wr_en) wr_addr <= wr_addr + ADDR_W'(1);
        if (accept) begin
          tmo_cnt <= '0;
          // Byte 0 clears the word so a flushed partial word is zero-filled
          if (byte_idx == '0) wr_data <= WORD_W'(shreg);
          for (int unsigned i = 1; i < WORD_BYTES; i++)
            if (byte_idx == IDX_W'(i)) wr_data[8*i +: 8] <= shreg;
          if (last_byte) begin
            wr_en    <= 1'b1;
            byte_idx <= '0;
          end else begin
            byte_idx <= byte_idx + IDX_W'(1);
          end
        end else if (done_pend) begin
          load_done <= 1'b1;
          done_pend <= 1'b0;
          wr_addr   <= '0;
          byte_idx  <= '0;
          tmo_cnt   <= '0;
        end else if (expire) begin
          tmo_cnt <= '0;
          if (byte_idx != '0) begin
            wr_en     <= 1'b1;
            done_pend <= 1'b1;
          end else begin
            load_done <= 1'b1;
            wr_addr   <= '0;
          end
        end else if (tmo_run) begin
          tmo_cnt <= tmo_cnt + TMO_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_loader.sv
// Directed bench for uart_rx_loader: a no-parity loader and an odd-parity receiver
// run at 16 clocks per bit, each scenario checked inline against hand-computed values.
module tb_uart_rx_loader;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned BITC   = 16;
  localparam int unsigned LIMIT  = 20 * BITC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rx0 = 1'b1, rx2 = 1'b1;
  logic en0 = 1'b0, en2 = 1'b0;

  logic              bv0, fe0, pe0, we0, ld0, busy0;
  logic [7:0]        bd0;
  logic [ADDR_W-1:0] wa0;
  logic [31:0]       wd0;
  logic              bv2, fe2, pe2, we2, ld2, busy2;
  logic [7:0]        bd2;
  logic [ADDR_W-1:0] wa2;
  logic [31:0]       wd2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  uart_rx_loader #(.CLK_FREQ(1600000), .BAUD(100000), .PARITY(0), .WORD_BYTES(4),
                   .ADDR_W(ADDR_W), .TIMEOUT_BITS(20)) d0 (
    .clk(clk), .rst_n(rst_n), .uart_rx(rx0), .en(en0),
    .byte_valid(bv0), .byte_data(bd0), .frame_err(fe0), .parity_err(pe0),
    .wr_en(we0), .wr_addr(wa0), .wr_data(wd0), .load_done(ld0), .busy(busy0));

  uart_rx_loader #(.CLK_FREQ(1600000), .BAUD(100000), .PARITY(2), .WORD_BYTES(4),
                   .ADDR_W(ADDR_W), .TIMEOUT_BITS(20)) d2 (
    .clk(clk), .rst_n(rst_n), .uart_rx(rx2), .en(en2),
    .byte_valid(bv2), .byte_data(bd2), .frame_err(fe2), .parity_err(pe2),
    .wr_en(we2), .wr_addr(wa2), .wr_data(wd2), .load_done(ld2), .busy(busy2));

  // Event recorder sampled on the falling edge
  int                cyc = 0;
  logic [7:0]        bq[$];
  int                last_bv_cyc = 0;
  logic [ADDR_W-1:0] waq[$];
  logic [31:0]       wdq[$];
  int                wcq[$];
  bit                wbq[$];
  int                ld_cnt = 0, ld_cyc = 0, fe_cnt = 0, pe_cnt = 0;
  int                bv2_cnt = 0, pe2_cnt = 0, fe2_cnt = 0;
  logic [7:0]        bd2_last = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bv0) begin bq.push_back(bd0); last_bv_cyc = cyc; end
    if (we0) begin waq.push_back(wa0); wdq.push_back(wd0); wcq.push_back(cyc); wbq.push_back(bv0); end
    if (ld0) begin ld_cnt++; ld_cyc = cyc; end
    if (fe0) fe_cnt++;
    if (pe0) pe_cnt++;
    if (bv2) begin bv2_cnt++; bd2_last = bd2; end
    if (pe2) pe2_cnt++;
    if (fe2) fe2_cnt++;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input bit which, input logic v);
    if (which) rx2 = v; else rx0 = v;
  endtask

  task automatic send_frame(input bit which, input logic [7:0] d, input bit has_par,
                            input logic pbit, input logic sbit);
    set_rx(which, 1'b0); wait_clks(BITC);
    for (int i = 0; i < 8; i++) begin set_rx(which, d[i]); wait_clks(BITC); end
    if (has_par) begin set_rx(which, pbit); wait_clks(BITC); end
    set_rx(which, sbit); wait_clks(BITC);
    set_rx(which, 1'b1); wait_clks(BITC);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    wait_clks(3);
    tests++;
    if ({bv0, fe0, pe0, we0, ld0, busy0} !== 6'b0) begin
      fails++; $display("FAIL reset_pulses: got %b want 000000", {bv0, fe0, pe0, we0, ld0, busy0});
    end
    tests++;
    if (bd0 !== 8'h00 || wa0 !== '0 || wd0 !== 32'h0) begin
      fails++; $display("FAIL reset_buses: got bd=%h wa=%h wd=%h want 0", bd0, wa0, wd0);
    end
    rst_n = 1'b1;
    wait_clks(4);
  endtask

  task automatic test_word();
    int b0, w0, l0;
    b0 = bq.size(); w0 = waq.size(); l0 = ld_cnt;
    en0 = 1'b1;
    send_frame(0, 8'h93, 0, 1'b0, 1'b1);
    send_frame(0, 8'h00, 0, 1'b0, 1'b1);
    send_frame(0, 8'h10, 0, 1'b0, 1'b1);
    send_frame(0, 8'h00, 0, 1'b0, 1'b1);
    tests++;
    if (bq.size() - b0 != 4) begin
      fails++; $display("FAIL word_bytes: got %0d want 4", bq.size() - b0);
    end else begin
      tests++;
      if ({bq[b0], bq[b0+1], bq[b0+2], bq[b0+3]} !== 32'h93001000) begin
        fails++; $display("FAIL word_byte_data: got %h want 93001000", {bq[b0], bq[b0+1], bq[b0+2], bq[b0+3]});
      end
    end
    tests++;
    if (waq.size() - w0 != 1) begin
      fails++; $display("FAIL word_wr_count: got %0d want 1", waq.size() - w0);
    end else begin
      tests++;
      if (waq[w0] !== 12'd0 || wdq[w0] !== 32'h00100093 || wbq[w0] !== 1'b1) begin
        fails++; $display("FAIL word_write: got addr=%h data=%h with_bv=%b want 000 00100093 1", waq[w0], wdq[w0], wbq[w0]);
      end
    end
    tests++;
    if (wa0 !== 12'd1 || busy0 !== 1'b1) begin
      fails++; $display("FAIL word_addr_after: got addr=%h busy=%b want 001 1", wa0, busy0);
    end
    wait_clks(LIMIT + 40);
    tests++;
    if (ld_cnt - l0 != 1 || ld_cyc - last_bv_cyc != int'(LIMIT) || waq.size() - w0 != 1) begin
      fails++; $display("FAIL word_timeout: got ld=%0d delay=%0d wr=%0d want 1 %0d 1", ld_cnt - l0, ld_cyc - last_bv_cyc, waq.size() - w0, LIMIT);
    end
    tests++;
    if (wa0 !== 12'd0 || busy0 !== 1'b0) begin
      fails++; $display("FAIL word_clear: got addr=%h busy=%b want 000 0", wa0, busy0);
    end
  endtask

  task automatic test_glitch();
    int b0, f0;
    b0 = bq.size(); f0 = fe_cnt;
    rx0 = 1'b0; wait_clks(5);
    rx0 = 1'b1; wait_clks(40);
    tests++;
    if (bq.size() != b0 || fe_cnt != f0 || pe_cnt != 0 || busy0 !== 1'b0) begin
      fails++; $display("FAIL glitch: got bytes=%0d ferr=%0d perr=%0d busy=%b want 0 0 0 0", bq.size() - b0, fe_cnt - f0, pe_cnt, busy0);
    end
  endtask

  task automatic test_frame_err();
    int b0, f0, w0, l0;
    b0 = bq.size(); f0 = fe_cnt; w0 = waq.size(); l0 = ld_cnt;
    send_frame(0, 8'h55, 0, 1'b0, 1'b0);
    tests++;
    if (fe_cnt - f0 != 1 || bq.size() != b0) begin
      fails++; $display("FAIL frame_err: got ferr=%0d bytes=%0d want 1 0", fe_cnt - f0, bq.size() - b0);
    end
    send_frame(0, 8'hAA, 0, 1'b0, 1'b1);
    tests++;
    if (bq.size() - b0 != 1 || bq[bq.size()-1] !== 8'hAA || fe_cnt - f0 != 1) begin
      fails++; $display("FAIL frame_recover: got bytes=%0d last=%h ferr=%0d want 1 aa 1", bq.size() - b0, bq[bq.size()-1], fe_cnt - f0);
    end
    wait_clks(LIMIT + 40);
    tests++;
    if (waq.size() - w0 != 1) begin
      fails++; $display("FAIL frame_flush_count: got %0d want 1", waq.size() - w0);
    end else begin
      tests++;
      if (waq[w0] !== 12'd0 || wdq[w0] !== 32'h000000AA || ld_cnt - l0 != 1 || ld_cyc != wcq[w0] + 1) begin
        fails++; $display("FAIL frame_flush: got addr=%h data=%h ld=%0d ld_gap=%0d want 000 000000aa 1 1", waq[w0], wdq[w0], ld_cnt - l0, ld_cyc - wcq[w0]);
      end
    end
  endtask

  task automatic test_parity();
    int v0, p0;
    v0 = bv2_cnt; p0 = pe2_cnt;
    send_frame(1, 8'h01, 1, 1'b0, 1'b1);
    tests++;
    if (bv2_cnt - v0 != 1 || bd2_last !== 8'h01 || pe2_cnt != p0) begin
      fails++; $display("FAIL parity_ok: got bv=%0d data=%h perr=%0d want 1 01 0", bv2_cnt - v0, bd2_last, pe2_cnt - p0);
    end
    send_frame(1, 8'h01, 1, 1'b1, 1'b1);
    tests++;
    if (pe2_cnt - p0 != 1 || bv2_cnt - v0 != 1 || fe2_cnt != 0) begin
      fails++; $display("FAIL parity_bad: got perr=%0d bv=%0d ferr=%0d want 1 1 0", pe2_cnt - p0, bv2_cnt - v0, fe2_cnt);
    end
  endtask

  task automatic test_flush();
    int w0, l0;
    logic [7:0] bytes [5];
    bytes = '{8'h13, 8'h01, 8'h20, 8'h00, 8'hEF};
    w0 = waq.size(); l0 = ld_cnt;
    for (int i = 0; i < 5; i++) send_frame(0, bytes[i], 0, 1'b0, 1'b1);
    wait_clks(LIMIT + 40);
    tests++;
    if (waq.size() - w0 != 2) begin
      fails++; $display("FAIL flush_count: got %0d want 2", waq.size() - w0);
    end else begin
      tests++;
      if (waq[w0] !== 12'd0 || wdq[w0] !== 32'h00200113) begin
        fails++; $display("FAIL flush_word0: got addr=%h data=%h want 000 00200113", waq[w0], wdq[w0]);
      end
      tests++;
      if (waq[w0+1] !== 12'd1 || wdq[w0+1] !== 32'h000000EF || wcq[w0+1] - last_bv_cyc != int'(LIMIT)) begin
        fails++; $display("FAIL flush_word1: got addr=%h data=%h delay=%0d want 001 000000ef %0d", waq[w0+1], wdq[w0+1], wcq[w0+1] - last_bv_cyc, LIMIT);
      end
      tests++;
      if (ld_cnt - l0 != 1 || ld_cyc != wcq[w0+1] + 1) begin
        fails++; $display("FAIL flush_done: got ld=%0d gap=%0d want 1 1", ld_cnt - l0, ld_cyc - wcq[w0+1]);
      end
    end
    tests++;
    if (wa0 !== 12'd0 || busy0 !== 1'b0) begin
      fails++; $display("FAIL flush_clear: got addr=%h busy=%b want 000 0", wa0, busy0);
    end
  endtask

  task automatic test_reset_mid_data();
    int b0;
    rx0 = 1'b0; wait_clks(BITC);
    rx0 = 1'b0; wait_clks(2 * BITC);
    tests++;
    if (busy0 !== 1'b1) begin
      fails++; $display("FAIL midreset_busy: got %b want 1", busy0);
    end
    rst_n = 1'b0;
    #2;
    tests++;
    if ({bv0, fe0, pe0, we0, ld0, busy0} !== 6'b0 || bd0 !== 8'h00 || wd0 !== 32'h0 || wa0 !== '0) begin
      fails++; $display("FAIL midreset_out: got flags=%b bd=%h wd=%h wa=%h want 0", {bv0, fe0, pe0, we0, ld0, busy0}, bd0, wd0, wa0);
    end
    rx0 = 1'b1;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(2 * BITC);
    b0 = bq.size();
    send_frame(0, 8'h3C, 0, 1'b0, 1'b1);
    tests++;
    if (bq.size() - b0 != 1 || bq[bq.size()-1] !== 8'h3C || busy0 !== 1'b1) begin
      fails++; $display("FAIL midreset_rx: got bytes=%0d last=%h busy=%b want 1 3c 1", bq.size() - b0, bq[bq.size()-1], busy0);
    end
  endtask

  task automatic test_en_drop();
    int w0, l0;
    w0 = waq.size(); l0 = ld_cnt;
    send_frame(0, 8'h11, 0, 1'b0, 1'b1);
    wait_clks(2);
    en0 = 1'b0;
    wait_clks(3);
    tests++;
    if (busy0 !== 1'b0 || wa0 !== 12'd0 || wd0 !== 32'h0) begin
      fails++; $display("FAIL endrop_clear: got busy=%b addr=%h data=%h want 0 000 0", busy0, wa0, wd0);
    end
    wait_clks(LIMIT + 40);
    tests++;
    if (waq.size() != w0 || ld_cnt != l0) begin
      fails++; $display("FAIL endrop_quiet: got wr=%0d ld=%0d want 0 0", waq.size() - w0, ld_cnt - l0);
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_glitch();
    test_frame_err();
    test_parity();
    test_flush();
    test_reset_mid_data();
    test_en_drop();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
